// File: rtl/alu_src_mux_pipe.sv
// N_IN:1 ALU operand-B source select, registered behind a valid/ready pipe stage with a skid register.
// Optional ALU_MUX_ERRCNT_EN adds err_count, a saturating count of accepted out-of-range selects.
module alu_src_mux_pipe #(
    parameter int WIDTH = 32,
    parameter int N_IN  = 4,
    parameter int SEL_W = $clog2(N_IN)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [N_IN*WIDTH-1:0] In_data,
    input  logic [SEL_W-1:0]      Selector,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [WIDTH-1:0]      OUT_data,
    output logic [SEL_W-1:0]      OUT_sel,
    output logic                  sel_err,
    output logic                  out_valid,
    input  logic                  out_ready
`ifdef ALU_MUX_ERRCNT_EN
    ,
    output logic [7:0]            err_count
`endif
);

    logic             accept;
    logic             xfer;
    logic             main_load;
    logic [WIDTH-1:0] cap_data;
    logic             cap_err;

    logic             skid_full;
    logic             skid_full_nxt;
    logic [WIDTH-1:0] skid_data;
    logic [SEL_W-1:0] skid_sel;
    logic             skid_err;
    logic             rdy_q;

    // rdy_q resets to 1 so the port reads 1 on the first cycle out of reset;
    // rst only masks it while asserted.
    assign in_ready  = rdy_q & ~rst;
    assign accept    = in_valid & in_ready;
    assign xfer      = out_valid & out_ready;
    assign main_load = ~out_valid | xfer;

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        cap_data = '0;
        cap_err  = 1'b1;
        for (int k = 0; k < N_IN; k++) begin
            if (Selector == SEL_W'(k)) begin
                cap_data = In_data[k*WIDTH +: WIDTH];
                cap_err  = 1'b0;
            end
        end
    end

    // Skid fills only when main is stalled; it cannot be full while accepting.
    always_comb begin
        skid_full_nxt = skid_full;
        if (main_load) begin
            skid_full_nxt = 1'b0;
        end else if (accept) begin
            skid_full_nxt = 1'b1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            OUT_data  <= '0;
            OUT_sel   <= '0;
            sel_err   <= 1'b0;
            skid_full <= 1'b0;
            rdy_q     <= 1'b1;
        end else begin
            if (main_load) begin
                if (skid_full) begin
                    out_valid <= 1'b1;
                    OUT_data  <= skid_data;
                    OUT_sel   <= skid_sel;
                    sel_err   <= skid_err;
                end else if (accept) begin
                    out_valid <= 1'b1;
                    OUT_data  <= cap_data;
                    OUT_sel   <= Selector;
                    sel_err   <= cap_err;
                end else begin
                    out_valid <= 1'b0;
                end
            end
            skid_full <= skid_full_nxt;
            rdy_q     <= ~skid_full_nxt;
        end
    end

    // NOTE: skid payload needs no reset; skid_full qualifies it.
    always_ff @(posedge clk) begin
        if (~main_load && accept) begin
            skid_data <= cap_data;
            skid_sel  <= Selector;
            skid_err  <= cap_err;
        end
    end

`ifdef ALU_MUX_ERRCNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            err_count <= 8'd0;
        end else if (accept && cap_err && err_count != 8'hFF) begin
            err_count <= err_count + 8'd1;
        end
    end
`endif

endmodule
